// File: rtl/writeback_arbiter_pkg.sv
// Shared types and sizes for the writeback arbiter and its LSU return buffer.
package writeback_arbiter_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_REGS);

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

  // Source of the write port winner in a given cycle.
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LSU  = 2'd2
  } wb_src_e;

  // One pending register write.
  typedef struct packed {
    reg_addr_t rd;
    reg_data_t data;
  } wb_req_t;

  // One-hot register mask for a register index.
  function automatic reg_mask_t reg_onehot(input reg_addr_t rd);
    return NUM_REGS'(1) << rd;
  endfunction

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// Small synchronous FIFO holding LSU returns until they win the write port.
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  wb_req_t data_i,
  input  logic    pop_i,
  output logic    full_o,
  output logic    empty_o,
  output wb_req_t head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_req_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic               do_push_c;
  logic               do_pop_c;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == CNT_W'(0));
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; a full FIFO may push when it also pops.
  always_comb begin
    do_push_c = push_i && (!full_o || pop_i);
    do_pop_c  = pop_i && !empty_o;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push_c, do_pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the buffer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk_i) begin
    if (do_push_c) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU results and buffered LSU returns onto the register file write port
// and tracks registers with outstanding loads.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ld_issue_i,
  input  logic [ADDR_WIDTH-1:0] ld_issue_rd_i,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [ADDR_WIDTH-1:0] alu_rd_i,
  input  logic [DATA_WIDTH-1:0] alu_data_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0] lsu_rd_i,
  input  logic [DATA_WIDTH-1:0] lsu_data_i,
  output logic                  rf_wr_enable_o,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr_o,
  output logic [DATA_WIDTH-1:0] rf_wr_data_o,
  output logic [NUM_REGS-1:0]   busy_o
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push_c;
  logic                fifo_pop_c;
  wb_req_t             fifo_head;
  wb_req_t             lsu_req_c;

  logic                force_c;
  wb_src_e             src_c;
  reg_addr_t           win_rd_c;
  reg_data_t           win_data_c;

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                wr_en_q,  wr_en_d;
  reg_addr_t           wr_addr_q, wr_addr_d;
  reg_data_t           wr_data_q, wr_data_d;
  logic                wr_lsu_q, wr_lsu_d;
  reg_mask_t           busy_q,   busy_d;
  reg_mask_t           set_c;
  reg_mask_t           clr_c;

  assign lsu_ready_o = !fifo_full;
  assign fifo_push_c = lsu_valid_i && lsu_ready_o;
  assign lsu_req_c   = '{rd: lsu_rd_i, data: lsu_data_i};

  // LSU return buffer.
  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push_c),
    .data_i  (lsu_req_c),
    .pop_i   (fifo_pop_c),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // A starved LSU head locks the ALU out for one cycle.
  assign force_c     = !fifo_empty && (starve_q == STARVE_W'(STARVE_LIMIT));
  assign alu_ready_o = !force_c;

  // Pick the winner for this cycle and prepare the registered write port.
  always_comb begin
    src_c      = WB_NONE;
    win_rd_c   = '0;
    win_data_c = '0;
    fifo_pop_c = 1'b0;
    if (alu_valid_i && !force_c) begin
      src_c      = WB_ALU;
      win_rd_c   = alu_rd_i;
      win_data_c = alu_data_i;
    end else if (!fifo_empty) begin
      src_c      = WB_LSU;
      win_rd_c   = fifo_head.rd;
      win_data_c = fifo_head.data;
      fifo_pop_c = 1'b1;
    end

    // Writes to x0 are consumed but never reach the register file.
    wr_en_d   = (src_c != WB_NONE) && (win_rd_c != '0);
    wr_lsu_d  = wr_en_d && (src_c == WB_LSU);
    wr_addr_d = wr_en_d ? win_rd_c   : wr_addr_q;
    wr_data_d = wr_en_d ? win_data_c : wr_data_q;
  end

  // Count cycles the buffered LSU head loses to the ALU.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || (src_c == WB_LSU)) begin
      starve_d = '0;
    end else if ((src_c == WB_ALU) && (starve_q < STARVE_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  // Pending-load scoreboard: clear as the RF captures the load data, set wins.
  always_comb begin
    set_c  = (ld_issue_i && (ld_issue_rd_i != '0)) ? reg_onehot(ld_issue_rd_i) : '0;
    clr_c  = (wr_en_q && wr_lsu_q) ? reg_onehot(wr_addr_q) : '0;
    busy_d = (busy_q & ~clr_c) | set_c;
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_lsu_q  <= 1'b0;
      busy_q    <= '0;
    end else begin
      starve_q  <= starve_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_lsu_q  <= wr_lsu_d;
      busy_q    <= busy_d;
    end
  end

  assign rf_wr_enable_o = wr_en_q;
  assign rf_wr_addr_o   = wr_addr_q;
  assign rf_wr_data_o   = wr_data_q;
  assign busy_o         = busy_q;

`ifdef ENABLE_ASSERTIONS
  // Issue logic must not let an ALU result overwrite a register awaiting a load.
  a_alu_to_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (alu_valid_i && alu_ready_o && (alu_rd_i != '0)) |-> !busy_q[alu_rd_i]);

  // A second load to a busy register is only allowed as the first one retires.
  a_load_to_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (ld_issue_i && (ld_issue_rd_i != '0)) |-> (!busy_q[ld_issue_rd_i] || clr_c[ld_issue_rd_i]));
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench with a write-port scoreboard for writeback_arbiter.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  logic      clk_i = 1'b0;
  logic      rst_ni = 1'b0;
  logic      ld_issue_i = 1'b0;
  reg_addr_t ld_issue_rd_i = '0;
  logic      alu_valid_i = 1'b0;
  logic      alu_ready_o;
  reg_addr_t alu_rd_i = '0;
  reg_data_t alu_data_i = '0;
  logic      lsu_valid_i = 1'b0;
  logic      lsu_ready_o;
  reg_addr_t lsu_rd_i = '0;
  reg_data_t lsu_data_i = '0;
  logic      rf_wr_enable_o;
  reg_addr_t rf_wr_addr_o;
  reg_data_t rf_wr_data_o;
  reg_mask_t busy_o;

  int n_vec = 0;
  int n_err = 0;

  wb_req_t alu_q[$];
  wb_req_t lsu_q[$];

  writeback_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .ld_issue_i     (ld_issue_i),
    .ld_issue_rd_i  (ld_issue_rd_i),
    .alu_valid_i    (alu_valid_i),
    .alu_ready_o    (alu_ready_o),
    .alu_rd_i       (alu_rd_i),
    .alu_data_i     (alu_data_i),
    .lsu_valid_i    (lsu_valid_i),
    .lsu_ready_o    (lsu_ready_o),
    .lsu_rd_i       (lsu_rd_i),
    .lsu_data_i     (lsu_data_i),
    .rf_wr_enable_o (rf_wr_enable_o),
    .rf_wr_addr_o   (rf_wr_addr_o),
    .rf_wr_data_o   (rf_wr_data_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every RF write must match the oldest expected write of its source.
  always @(negedge clk_i) begin
    if (rst_ni && rf_wr_enable_o) begin
      n_vec++;
      if (lsu_q.size() > 0 && rf_wr_addr_o == lsu_q[0].rd) begin
        if (rf_wr_data_o !== lsu_q[0].data) begin
          n_err++;
          $display("FAIL lsu_write x%0d: got data 0x%0h, expected 0x%0h",
                   rf_wr_addr_o, rf_wr_data_o, lsu_q[0].data);
        end
        void'(lsu_q.pop_front());
      end else if (alu_q.size() > 0) begin
        if (rf_wr_addr_o !== alu_q[0].rd || rf_wr_data_o !== alu_q[0].data) begin
          n_err++;
          $display("FAIL alu_write: got x%0d=0x%0h, expected x%0d=0x%0h",
                   rf_wr_addr_o, rf_wr_data_o, alu_q[0].rd, alu_q[0].data);
        end
        void'(alu_q.pop_front());
      end else begin
        n_err++;
        $display("FAIL spurious_write: got x%0d=0x%0h, expected no write",
                 rf_wr_addr_o, rf_wr_data_o);
      end
    end
  end

  // One clock cycle of stimulus, called just after a rising edge.
  task automatic step(input logic av, input reg_addr_t ard, input reg_data_t ad,
                      input logic lv, input reg_addr_t lrd, input reg_data_t ld,
                      input logic iv, input reg_addr_t ird,
                      output logic a_rdy, output logic l_rdy);
    alu_valid_i = av; alu_rd_i = ard; alu_data_i = ad;
    lsu_valid_i = lv; lsu_rd_i = lrd; lsu_data_i = ld;
    ld_issue_i  = iv; ld_issue_rd_i = ird;
    @(negedge clk_i);
    a_rdy = alu_ready_o;
    l_rdy = lsu_ready_o;
    if (av && a_rdy && ard != '0) alu_q.push_back('{rd: ard, data: ad});
    if (lv && l_rdy && lrd != '0) lsu_q.push_back('{rd: lrd, data: ld});
    @(posedge clk_i);
    #1;
    alu_valid_i = 1'b0;
    lsu_valid_i = 1'b0;
    ld_issue_i  = 1'b0;
  endtask

  task automatic idle();
    logic a, l;
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, a, l);
  endtask

  initial begin
    logic a_rdy, l_rdy;
    logic [15:0] exp_alu_rdy;
    logic [15:0] exp_lsu_rdy;
    int ai;
    int lj;

    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #1;
    chk("reset_wr_enable", 32'(rf_wr_enable_o), 32'd0);
    chk("reset_wr_addr",   32'(rf_wr_addr_o),   32'd0);
    chk("reset_wr_data",   rf_wr_data_o,        32'd0);
    chk("reset_busy",      busy_o,              32'd0);
    chk("reset_lsu_ready", 32'(lsu_ready_o),    32'd1);
    chk("reset_alu_ready", 32'(alu_ready_o),    32'd1);
    @(posedge clk_i); #1;

    // 1: ALU write visible one edge after acceptance.
    step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, '0, a_rdy, l_rdy);
    chk("t1_enable", 32'(rf_wr_enable_o), 32'd1);
    chk("t1_addr",   32'(rf_wr_addr_o),   32'd5);
    chk("t1_data",   rf_wr_data_o,        32'hDEAD_BEEF);
    idle();
    chk("t1_enable_drop", 32'(rf_wr_enable_o), 32'd0);
    chk("t1_addr_hold",   32'(rf_wr_addr_o),   32'd5);

    // 2: load flow through the buffer and scoreboard.
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, a_rdy, l_rdy);
    chk("t2_busy_set", 32'(busy_o[7]), 32'd1);
    step(1'b0, '0, '0, 1'b1, 5'd7, 32'h1234, 1'b0, '0, a_rdy, l_rdy);
    chk("t2_busy_held", 32'(busy_o[7]), 32'd1);
    idle();
    chk("t2_enable", 32'(rf_wr_enable_o), 32'd1);
    chk("t2_addr",   32'(rf_wr_addr_o),   32'd7);
    chk("t2_data",   rf_wr_data_o,        32'h1234);
    chk("t2_busy_at_write", 32'(busy_o[7]), 32'd1);
    idle();
    chk("t2_busy_clear", 32'(busy_o[7]), 32'd0);

    // 3: ALU every cycle vs three LSU returns; LSU forced in at cycles 5, 10, 15.
    exp_alu_rdy = 16'b0111_1011_1101_1111;
    exp_lsu_rdy = 16'hF843;
    ai = 0;
    lj = 0;
    for (int c = 0; c < 16; c++) begin
      step(1'b1, reg_addr_t'(24 + (ai % 8)), 32'hA000_0000 + 32'(ai),
           (lj < 3), reg_addr_t'(20 + lj), 32'hB000_0000 + 32'(lj),
           1'b0, '0, a_rdy, l_rdy);
      chk($sformatf("t3_alu_ready_c%0d", c), 32'(a_rdy), 32'(exp_alu_rdy[c]));
      chk($sformatf("t3_lsu_ready_c%0d", c), 32'(l_rdy), 32'(exp_lsu_rdy[c]));
      if (a_rdy) ai++;
      if (lj < 3 && l_rdy) lj++;
    end
    idle();
    idle();
    chk("t3_lsu_drained", 32'(lsu_q.size()), 32'd0);
    chk("t3_alu_drained", 32'(alu_q.size()), 32'd0);

    // 4: x0 writes are consumed silently and never mark busy.
    step(1'b1, 5'd0, 32'h1111_1111, 1'b1, 5'd0, 32'h2222_2222, 1'b1, 5'd0, a_rdy, l_rdy);
    chk("t4_alu_accepted", 32'(a_rdy), 32'd1);
    chk("t4_lsu_accepted", 32'(l_rdy), 32'd1);
    chk("t4_enable_a", 32'(rf_wr_enable_o), 32'd0);
    chk("t4_busy0",    32'(busy_o[0]),      32'd0);
    idle();
    chk("t4_enable_b", 32'(rf_wr_enable_o), 32'd0);
    idle();
    chk("t4_enable_c", 32'(rf_wr_enable_o), 32'd0);
    chk("t4_busy_all", busy_o, 32'd0);

    // 5: new load to x9 on the edge the old one retires keeps busy set.
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9, a_rdy, l_rdy);
    step(1'b0, '0, '0, 1'b1, 5'd9, 32'h0000_0099, 1'b0, '0, a_rdy, l_rdy);
    idle();
    chk("t5_retire_enable", 32'(rf_wr_enable_o), 32'd1);
    chk("t5_retire_addr",   32'(rf_wr_addr_o),   32'd9);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9, a_rdy, l_rdy);
    chk("t5_busy_collision", 32'(busy_o[9]), 32'd1);
    step(1'b0, '0, '0, 1'b1, 5'd9, 32'h0000_0077, 1'b0, '0, a_rdy, l_rdy);
    idle();
    chk("t5_second_write", 32'(rf_wr_addr_o), 32'd9);
    idle();
    chk("t5_busy_clear", 32'(busy_o[9]), 32'd0);

    // 6: reset with a full buffer and pending loads.
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd3, a_rdy, l_rdy);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd4, a_rdy, l_rdy);
    step(1'b1, 5'd12, 32'hC000_0012, 1'b1, 5'd3, 32'hD000_0003, 1'b0, '0, a_rdy, l_rdy);
    step(1'b1, 5'd13, 32'hC000_0013, 1'b1, 5'd4, 32'hD000_0004, 1'b0, '0, a_rdy, l_rdy);
    step(1'b1, 5'd14, 32'hC000_0014, 1'b0, '0, '0, 1'b0, '0, a_rdy, l_rdy);
    chk("t6_full", 32'(l_rdy), 32'd0);
    chk("t6_busy_pre", busy_o, 32'h0000_0018);
    @(negedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    lsu_q.delete();
    chk("t6_rst_enable",    32'(rf_wr_enable_o), 32'd0);
    chk("t6_rst_busy",      busy_o,              32'd0);
    chk("t6_rst_lsu_ready", 32'(lsu_ready_o),    32'd1);
    chk("t6_rst_addr",      32'(rf_wr_addr_o),   32'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    idle();
    idle();
    chk("t6_post_enable", 32'(rf_wr_enable_o), 32'd0);
    chk("t6_post_busy",   busy_o,              32'd0);
    chk("t6_post_ready",  32'(lsu_ready_o),    32'd1);
    chk("end_alu_q_empty", 32'(alu_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
